// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: init passthrough, periodic auto-refresh, round-robin write/read grants.
// Bus mux is combinational on state (0 cycles); grants follow the IDLE decision by 1 cycle; engines are never preempted.
module sdram_arbiter #(
    parameter int REF_PERIOD = 750,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 7
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        flag_wr_end,
    input  logic        flag_rd_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_ba,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_ba,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_req,
    output logic        ref_ovf,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_ba
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam logic [4:0] S_INIT  = 5'b00001;
    localparam logic [4:0] S_IDLE  = 5'b00010;
    localparam logic [4:0] S_AREF  = 5'b00100;
    localparam logic [4:0] S_WRITE = 5'b01000;
    localparam logic [4:0] S_READ  = 5'b10000;

    localparam int RW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int AW = $clog2(T_RP + T_RFC + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REF_PERIOD - 1);
    localparam logic [AW-1:0] A_RP     = AW'(T_RP);
    localparam logic [AW-1:0] A_LAST   = AW'(T_RP + T_RFC);

    logic [4:0]    state, state_nxt;
    logic          last_served;
    logic [RW-1:0] ref_cnt;
    logic [AW-1:0] aref_cnt;
    logic          wrap, aref_start;

    assign wrap       = init_end && (ref_cnt == REF_LAST);
    assign aref_start = (state == S_AREF) && (aref_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_end) state_nxt = S_IDLE;
            S_IDLE: begin
                if (ref_req)
                    state_nxt = S_AREF;
                else if (wr_req && (!rd_req || last_served))
                    state_nxt = S_WRITE;
                else if (rd_req)
                    state_nxt = S_READ;
            end
            S_AREF:  if (aref_cnt == A_LAST) state_nxt = S_IDLE;
            S_WRITE: if (flag_wr_end) state_nxt = S_IDLE;
            S_READ:  if (flag_rd_end) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= S_INIT;
            last_served <= 1'b1;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            aref_cnt    <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= (state_nxt == S_WRITE);
            rd_en <= (state_nxt == S_READ);
            if (state == S_IDLE && state_nxt == S_WRITE)
                last_served <= 1'b0;
            else if (state == S_IDLE && state_nxt == S_READ)
                last_served <= 1'b1;
            // Counter is zero whenever AREF is (re)entered.
            if (state == S_AREF && state_nxt == S_AREF)
                aref_cnt <= aref_cnt + AW'(1);
            else
                aref_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ref_cnt <= '0;
            ref_req <= 1'b0;
            ref_ovf <= 1'b0;
        end else begin
            if (!init_end || wrap)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + RW'(1);
            // A wrap coinciding with the AREF clear keeps the request pending.
            if (wrap)
                ref_req <= 1'b1;
            else if (aref_start)
                ref_req <= 1'b0;
            if (wrap && ref_req)
                ref_ovf <= 1'b1;
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'h000;
        sdram_ba   = 2'b00;
        case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                if (aref_cnt == '0) begin
                    sdram_cmd  = CMD_PRE;
                    sdram_addr = 12'h400;
                end else if (aref_cnt == A_RP) begin
                    sdram_cmd  = CMD_AREF;
                end
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init passthrough, arbitration table, refresh timing, overflow, reset abort.
module tb_sdram_arbiter;

    localparam logic [3:0]  NOP    = 4'b0111;
    localparam logic [3:0]  PRE    = 4'b0010;
    localparam logic [3:0]  AREF   = 4'b0001;
    localparam logic [3:0]  WR_CMD = 4'b0100;
    localparam logic [11:0] WR_ADR = 12'hA5A;
    localparam logic [1:0]  WR_BA  = 2'b01;
    localparam logic [3:0]  RD_CMD = 4'b0101;
    localparam logic [11:0] RD_ADR = 12'h35C;
    localparam logic [1:0]  RD_BA  = 2'b10;

    logic        CLK, RSTn, init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        wr_req, rd_req, flag_wr_end, flag_rd_end;
    logic [3:0]  wr_cmd, rd_cmd;
    logic [11:0] wr_addr, rd_addr;
    logic [1:0]  wr_ba, rd_ba;
    logic        wr_en, rd_en, ref_req, ref_ovf;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;

    sdram_arbiter dut (
        .CLK(CLK), .RSTn(RSTn), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .wr_req(wr_req), .rd_req(rd_req),
        .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .wr_en(wr_en), .rd_en(rd_en), .ref_req(ref_req), .ref_ovf(ref_ovf),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] aref_exp(input int k);
        if (k == 0)      return PRE;
        else if (k == 2) return AREF;
        else             return NOP;
    endfunction

    typedef struct {
        logic wr;
        logic rd;
        logic exp_wr;
        logic exp_rd;
    } arb_vec_t;

    arb_vec_t vecs[8];

    task automatic check_aref_seq(input string tag);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk({tag, "_cmd"}, 12'(sdram_cmd), 12'(aref_exp(k)));
            chk({tag, "_addr"}, sdram_addr, (k == 0) ? 12'h400 : 12'h000);
            chk({tag, "_wr_en"}, 12'(wr_en), 12'd0);
            if (k == 1) chk({tag, "_ref_req_clr"}, 12'(ref_req), 12'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0};

        RSTn = 1'b0; init_end = 1'b0;
        init_cmd = 4'b1001; init_addr = 12'h123;
        wr_req = 1'b0; rd_req = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        wr_cmd = WR_CMD; wr_addr = WR_ADR; wr_ba = WR_BA;
        rd_cmd = RD_CMD; rd_addr = RD_ADR; rd_ba = RD_BA;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_cmd", 12'(sdram_cmd), 12'(init_cmd));
        chk("rst_addr", sdram_addr, init_addr);
        chk("rst_ba", 12'(sdram_ba), 12'd0);
        chk("rst_grants", 12'({wr_en, rd_en}), 12'd0);
        chk("rst_ref", 12'({ref_req, ref_ovf}), 12'd0);

        // Init passthrough for 100 cycles with init_end low
        RSTn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            init_cmd  = 4'(i);
            init_addr = 12'(i * 7);
            @(negedge CLK);
            chk("init_cmd", 12'(sdram_cmd), 12'(init_cmd));
            chk("init_addr", sdram_addr, init_addr);
        end
        init_end = 1'b1;
        t0 = cyc;
        chk("init_last_cmd", 12'(sdram_cmd), 12'(init_cmd));
        @(negedge CLK);
        chk("idle_cmd", 12'(sdram_cmd), 12'(NOP));
        chk("idle_addr", sdram_addr, 12'h000);

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            wr_req = vecs[i].wr;
            rd_req = vecs[i].rd;
            @(negedge CLK);
            chk($sformatf("arb%0d_wr_en", i), 12'(wr_en), 12'(vecs[i].exp_wr));
            chk($sformatf("arb%0d_rd_en", i), 12'(rd_en), 12'(vecs[i].exp_rd));
            chk($sformatf("arb%0d_cmd", i), 12'(sdram_cmd),
                vecs[i].exp_wr ? 12'(WR_CMD) : vecs[i].exp_rd ? 12'(RD_CMD) : 12'(NOP));
            chk($sformatf("arb%0d_addr", i), sdram_addr,
                vecs[i].exp_wr ? WR_ADR : vecs[i].exp_rd ? RD_ADR : 12'h000);
            flag_wr_end = vecs[i].exp_wr;
            flag_rd_end = vecs[i].exp_rd;
            wr_req = 1'b0;
            rd_req = 1'b0;
            @(negedge CLK);
            flag_wr_end = 1'b0;
            flag_rd_end = 1'b0;
            chk($sformatf("arb%0d_release", i), 12'({wr_en, rd_en}), 12'd0);
            chk($sformatf("arb%0d_idle_cmd", i), 12'(sdram_cmd), 12'(NOP));
        end

        // First refresh while idle
        for (int n = 0; n < 1000 && !ref_req; n++) @(negedge CLK);
        chk("ref_rise_cycle", 12'(cyc - t0), 12'd750);
        chk("ref_rise_idle_cmd", 12'(sdram_cmd), 12'(NOP));
        check_aref_seq("aref1");
        @(negedge CLK);
        chk("aref1_done_cmd", 12'(sdram_cmd), 12'(NOP));
        chk("aref1_done_ref", 12'({ref_req, ref_ovf}), 12'd0);

        // Refresh arriving during READ, write pending behind it
        rd_req = 1'b1;
        @(negedge CLK);
        chk("rd_grant", 12'(rd_en), 12'd1);
        for (int n = 0; n < 1000 && !ref_req; n++) @(negedge CLK);
        chk("ref_in_read", 12'(ref_req), 12'd1);
        wr_req = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rd_held", 12'(rd_en), 12'd1);
        chk("rd_held_cmd", 12'(sdram_cmd), 12'(RD_CMD));
        chk("rd_held_ba", 12'(sdram_ba), 12'(RD_BA));
        chk("rd_held_no_wr", 12'(wr_en), 12'd0);
        flag_rd_end = 1'b1;
        rd_req = 1'b0;
        @(negedge CLK);
        flag_rd_end = 1'b0;
        chk("rd_end_idle", 12'({wr_en, rd_en}), 12'd0);
        chk("rd_end_idle_cmd", 12'(sdram_cmd), 12'(NOP));
        check_aref_seq("aref2");
        @(negedge CLK);
        chk("aref2_idle_wr_en", 12'(wr_en), 12'd0);
        @(negedge CLK);
        chk("wr_after_aref", 12'(wr_en), 12'd1);
        chk("wr_after_aref_cmd", 12'(sdram_cmd), 12'(WR_CMD));
        chk("no_ovf_yet", 12'(ref_ovf), 12'd0);

        // Foreign end flag ignored, then long write forces overflow
        flag_rd_end = 1'b1;
        @(negedge CLK);
        flag_rd_end = 1'b0;
        chk("rd_end_in_write", 12'(wr_en), 12'd1);
        repeat (1600) @(negedge CLK);
        chk("ovf_set", 12'(ref_ovf), 12'd1);
        chk("ovf_ref_req", 12'(ref_req), 12'd1);
        chk("ovf_wr_held", 12'(wr_en), 12'd1);
        flag_wr_end = 1'b1;
        wr_req = 1'b0;
        @(negedge CLK);
        flag_wr_end = 1'b0;
        chk("wr_end_idle", 12'(wr_en), 12'd0);
        @(negedge CLK);
        chk("aref3_pre", 12'(sdram_cmd), 12'(PRE));
        repeat (3) @(negedge CLK);
        chk("aref3_c3_cmd", 12'(sdram_cmd), 12'(NOP));
        chk("ovf_sticky", 12'(ref_ovf), 12'd1);

        // Reset at AREF cycle 3
        RSTn = 1'b0;
        #1;
        chk("abort_cmd", 12'(sdram_cmd), 12'(init_cmd));
        chk("abort_addr", sdram_addr, init_addr);
        chk("abort_ref", 12'({ref_req, ref_ovf}), 12'd0);
        chk("abort_grants", 12'({wr_en, rd_en}), 12'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("rerun_idle_cmd", 12'(sdram_cmd), 12'(NOP));
        wr_req = 1'b1;
        rd_req = 1'b1;
        @(negedge CLK);
        chk("rerun_tie_wr", 12'({wr_en, rd_en}), 12'b10);
        wr_req = 1'b0;
        rd_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
